// File: rtl/sim_run_controller.sv
// Run sequencer: DUT reset hold, cycle counter, dump window,
// pass/fail arbitration across N_SRC checkers and a watchdog.
//
// Ports:
//   clock, reset     : clock and synchronous active-high reset
//   cfg_max_cycles   : watchdog limit (0 disables)
//   cfg_dump_start   : first cycle_count with dump_en high
//   cfg_dump_stop    : first cycle_count with dump_en low (0 = never)
//   src_success      : per-source pass reports
//   src_failure      : per-source fail reports
//   dut_reset        : reset driven to the DUT
//   cycle_count      : cycles since controller reset (saturating)
//   dump_en          : waveform dump window active
//   done, passed     : sticky verdict and its polarity
//   fail_code        : 0 none, 1 source failure, 2 timeout
//   fail_src         : lowest failing source index
module sim_run_controller #(
    parameter int N_SRC        = 2,
    parameter int RESET_CYCLES = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = 64,
    localparam int FW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CW-1:0]    cfg_max_cycles,
    input  logic [CW-1:0]    cfg_dump_start,
    input  logic [CW-1:0]    cfg_dump_stop,
    input  logic [N_SRC-1:0] src_success,
    input  logic [N_SRC-1:0] src_failure,
    output logic             dut_reset,
    output logic [CW-1:0]    cycle_count,
    output logic             dump_en,
    output logic             done,
    output logic             passed,
    output logic [1:0]       fail_code,
    output logic [FW-1:0]    fail_src
);

    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [N_SRC-1:0] pass_q, pass_d;
    logic             passed_q, passed_d;
    logic [1:0]       code_q, code_d;
    logic [FW-1:0]    src_q, src_d;

    logic [FW-1:0]    low_idx;
    logic             timeout;

    // Lowest-index failing source: scan downward so the lowest wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_failure[i]) begin
                low_idx = FW'(i);
            end
        end
    end

    assign timeout = (cfg_max_cycles != '0) && (cnt_q >= cfg_max_cycles);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            hold_q   <= '0;
            drain_q  <= '0;
            pass_q   <= '0;
            passed_q <= 1'b0;
            code_q   <= 2'd0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            drain_q  <= drain_d;
            pass_q   <= pass_d;
            passed_q <= passed_d;
            code_q   <= code_d;
            src_q    <= src_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        drain_d  = drain_q;
        pass_d   = pass_q;
        passed_d = passed_q;
        code_d   = code_q;
        src_d    = src_q;

        // Counter freezes once the verdict is final; never wraps.
        if (state_q != S_DONE && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_HOLD: begin
                if (hold_q == HW'(RESET_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                if (state_q == S_RUN) begin
                    pass_d = pass_q | src_success;
                end
                if (|src_failure) begin
                    state_d  = S_DONE;
                    passed_d = 1'b0;
                    code_d   = 2'd1;
                    src_d    = low_idx;
                end else if (timeout) begin
                    state_d  = S_DONE;
                    passed_d = 1'b0;
                    code_d   = 2'd2;
                end else if (state_q == S_RUN) begin
                    if (&pass_d) begin
                        drain_d = '0;
                        if (DRAIN_CYCLES == 0) begin
                            state_d  = S_DONE;
                            passed_d = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end else if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d  = S_DONE;
                    passed_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign dut_reset   = (state_q == S_HOLD);
    assign cycle_count = cnt_q;
    assign done        = (state_q == S_DONE);
    assign passed      = passed_q;
    assign fail_code   = code_q;
    assign fail_src    = src_q;

    assign dump_en = (cnt_q >= cfg_dump_start)
                   && ((cfg_dump_stop == '0) || (cnt_q < cfg_dump_stop))
                   && (state_q != S_DONE);

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Synthesizable run sequencer for the simulation harness.
- Holds DUT reset for a fixed number of cycles, then counts cycles, and gates the waveform-dump window.
- Arbitrates pass/fail reports from N_SRC independent checkers into one final verdict, and enforces a watchdog timeout.
- Sits between the top-level driver's clock/reset and the harness `io_success`-style completion signals; the driver only samples `done` and `passed`.

Parameters:
- N_SRC, 2, number of pass/fail reporting sources (1..16)
- RESET_CYCLES, 8, cycles `dut_reset` is held high after controller reset (>=1)
- DRAIN_CYCLES, 4, cycles waited after all sources pass before declaring `done` (0 allowed)
- CW, 64, cycle counter width

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high controller reset
- cfg_max_cycles  in  CW  watchdog limit; 0 disables
- cfg_dump_start  in  CW  first cycle_count value with `dump_en`=1
- cfg_dump_stop  in  CW  first cycle_count value with `dump_en`=0; 0 = never stop
- src_success  in  N_SRC  per-source pass pulse/level
- src_failure  in  N_SRC  per-source fail pulse/level
- dut_reset  out  1  reset driven to DUT/harness
- cycle_count  out  CW  cycles since controller reset
- dump_en  out  1  waveform dump window active
- done  out  1  verdict final (sticky)
- passed  out  1  valid when `done`: 1 = pass
- fail_code  out  2  0 none, 1 source failure, 2 timeout
- fail_src  out  clog2(N_SRC) (min 1)  lowest-index failing source when `fail_code`=1, else 0

Behaviour:
- Reset (sync): state=HOLD, cycle_count=0, hold counter=0, pass_seen=0.
  - Outputs during reset: `dut_reset`=1, `done`=0, `passed`=0, `fail_code`=0, `fail_src`=0, `dump_en` per formula.
- States: HOLD, RUN, DRAIN, DONE.
- HOLD:
  - `dut_reset`=1; src inputs ignored.
  - After exactly RESET_CYCLES cycles in HOLD, go to RUN. `dut_reset` is low from the first RUN cycle.
- RUN:
  - `src_success[i]`=1 sets sticky `pass_seen[i]`.
  - When `pass_seen` (including this cycle's sets) is all ones: go to DRAIN, or directly to DONE-pass if DRAIN_CYCLES=0.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, then DONE with `passed`=1.
  - Failures and timeout are still checked here.
- Failure check (RUN or DRAIN):
  - Any `src_failure` bit high -> DONE, `passed`=0, `fail_code`=1, `fail_src`=lowest set index.
- Timeout (RUN or DRAIN):
  - Condition: `cfg_max_cycles`!=0 and `cycle_count` >= `cfg_max_cycles` -> DONE, `fail_code`=2.
- Same-cycle priority: source failure > timeout > pass completion.
  - A source with both success and failure high counts as failure.
- DONE:
  - All verdict outputs held; `done`=1 from the cycle after the deciding edge.
  - Inputs ignored; `dut_reset` stays 0; `cycle_count` frozen.
  - Only `reset` leaves DONE.
- cycle_count:
  - +1 every cycle in HOLD/RUN/DRAIN; saturates at all-ones (no wrap).
- dump_en (combinational from registered count/state):
  - (`cycle_count` >= `cfg_dump_start`) && (`cfg_dump_stop`==0 || `cycle_count` < `cfg_dump_stop`) && state!=DONE.
  - `cfg_dump_stop` <= `cfg_dump_start` (stop nonzero) -> never enabled.
- cfg_* inputs are treated as quasi-static but are sampled live each cycle; no latching.
- Reset asserted mid-RUN/DRAIN/DONE:
  - Next cycle fully returns to the reset values.
  - Pending passes are discarded.

Test Plan:
- Basic pass, N_SRC=2, RESET_CYCLES=8, DRAIN_CYCLES=4:
  - Release reset; pulse `src_success[0]` at count 20 and `src_success[1]` at count 30.
  - Required: `dut_reset` low at count 8; `done`=1, `passed`=1, `fail_code`=0; `cycle_count` frozen at 35.
- Failure wins:
  - `src_success`=2'b11 and `src_failure`=2'b10 in the same cycle at count 15.
  - Required: `done`=1, `passed`=0, `fail_code`=1, `fail_src`=1.
- Timeout:
  - `cfg_max_cycles`=50, no reports.
  - Required: `done`=1 with `fail_code`=2 after the edge at `cycle_count`=50; `cycle_count` frozen at 51.
- Failure in DRAIN:
  - All sources pass at count 20; `src_failure[0]` at count 22.
  - Required: `fail_code`=1, `fail_src`=0, `passed`=0.
- Dump window:
  - `cfg_dump_start`=10, `cfg_dump_stop`=14.
  - Required: `dump_en` high for exactly count 10..13. A second run with start=14, stop=10 -> never high.
- Reset mid-run:
  - Assert `reset` at count 25 with one source passed; run again.
  - Required: count restarts at 0, `dut_reset`=1 for 8 cycles, and the earlier pass is not remembered.
